// File: rtl/mdio_frame_engine.sv
`default_nettype none
// ============================================================================
// Module      : mdio_frame_engine
// Description : Bit-level Clause 22 MDIO master. Takes one read or write
//               command at a time on a valid/ready port, serialises the frame
//               on MDC/MDIO through an external tri-state pad, and reports
//               read data plus turnaround status on a one-cycle response.
// Ports       : clk, rst_n             - clock, async active-low reset
//               req_valid/req_ready    - command handshake
//               req_op                 - 1 = read, 0 = write
//               req_phy_addr/reg_addr  - 5-bit PHY / register address
//               req_wdata              - 16-bit write data
//               rsp_valid              - one-cycle completion pulse
//               rsp_rdata/rsp_ta_err   - read data / turnaround error
//               busy                   - frame in progress
//               mdc                    - MDIO clock
//               mdio_i/mdio_o/mdio_t   - pad input / output / release (1=Z)
// Revision    : 1.0 - initial release
// ============================================================================
module mdio_frame_engine #(
    parameter int C_CLK_DIV       = 25,
    parameter int C_PREAMBLE_TIME = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_op,
    input  logic [4:0]  req_phy_addr,
    input  logic [4:0]  req_reg_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_ta_err,
    output logic        busy,
    output logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_t
);

    localparam int DIV_W   = (C_CLK_DIV > 1) ? $clog2(C_CLK_DIV) : 1;
    localparam int CNT_MAX = (C_PREAMBLE_TIME > 16) ? C_PREAMBLE_TIME : 16;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(C_CLK_DIV - 1);
    localparam logic [CNT_W-1:0] C_PRE_LAST =
        CNT_W'((C_PREAMBLE_TIME > 0) ? (C_PREAMBLE_TIME - 1) : 0);
    localparam logic [CNT_W-1:0] C_HDR_LAST = CNT_W'(13);
    localparam logic [CNT_W-1:0] C_TA_LAST  = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_DAT_LAST = CNT_W'(15);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_HEADER   = 3'd2,
        S_TA       = 3'd3,
        S_DATA     = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [DIV_W-1:0]   r_div, w_div_nxt;
    logic               r_half, w_half_nxt;       // 0 = mdc low half, 1 = high half
    logic               r_mdc, w_mdc_nxt;
    logic [CNT_W-1:0]   r_bit, w_bit_nxt;         // bit index within current state
    logic               r_op, w_op_nxt;
    logic [31:0]        r_tx, w_tx_nxt;           // header + TA + wdata, MSB first
    logic [15:0]        r_rx, w_rx_nxt;
    logic               r_ta_err, w_ta_err_nxt;
    logic               r_mdio_o, w_mdio_o_nxt;
    logic               r_mdio_t, w_mdio_t_nxt;
    logic [15:0]        r_rsp_rdata, w_rsp_rdata_nxt;
    logic               r_rsp_ta_err, w_rsp_ta_err_nxt;

    logic               w_idle_like;
    logic               w_accept;
    logic               w_tick;
    logic               w_rise;
    logic               w_fall;
    logic               w_last;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_div        <= '0;
            r_half       <= 1'b0;
            r_mdc        <= 1'b0;
            r_bit        <= '0;
            r_op         <= 1'b0;
            r_tx         <= '0;
            r_rx         <= '0;
            r_ta_err     <= 1'b0;
            r_mdio_o     <= 1'b1;
            r_mdio_t     <= 1'b1;
            r_rsp_rdata  <= '0;
            r_rsp_ta_err <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_div        <= w_div_nxt;
            r_half       <= w_half_nxt;
            r_mdc        <= w_mdc_nxt;
            r_bit        <= w_bit_nxt;
            r_op         <= w_op_nxt;
            r_tx         <= w_tx_nxt;
            r_rx         <= w_rx_nxt;
            r_ta_err     <= w_ta_err_nxt;
            r_mdio_o     <= w_mdio_o_nxt;
            r_mdio_t     <= w_mdio_t_nxt;
            r_rsp_rdata  <= w_rsp_rdata_nxt;
            r_rsp_ta_err <= w_rsp_ta_err_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Timing strobes
    // ------------------------------------------------------------------------
    assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_accept    = req_valid && w_idle_like;
    assign w_tick      = (r_div == C_DIV_LAST);
    assign w_rise      = !w_idle_like && w_tick && !r_half;
    assign w_fall      = !w_idle_like && w_tick &&  r_half;

    always_comb begin
        w_last = 1'b0;
        case (r_state)
            S_PREAMBLE: w_last = (r_bit == C_PRE_LAST);
            S_HEADER:   w_last = (r_bit == C_HDR_LAST);
            S_TA:       w_last = (r_bit == C_TA_LAST);
            S_DATA:     w_last = (r_bit == C_DAT_LAST);
            default:    w_last = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_div_nxt        = r_div;
        w_half_nxt       = r_half;
        w_mdc_nxt        = r_mdc;
        w_bit_nxt        = r_bit;
        w_op_nxt         = r_op;
        w_tx_nxt         = r_tx;
        w_rx_nxt         = r_rx;
        w_ta_err_nxt     = r_ta_err;
        w_rsp_rdata_nxt  = r_rsp_rdata;
        w_rsp_ta_err_nxt = r_rsp_ta_err;
        w_mdio_o_nxt     = 1'b1;
        w_mdio_t_nxt     = 1'b1;

        if (w_idle_like) begin
            // DONE behaves like IDLE so a waiting request starts with no gap.
            w_state_nxt = S_IDLE;
            w_mdc_nxt   = 1'b0;
            if (w_accept) begin
                w_state_nxt  = (C_PREAMBLE_TIME == 0) ? S_HEADER : S_PREAMBLE;
                w_op_nxt     = req_op;
                w_tx_nxt     = {2'b01, (req_op ? 2'b10 : 2'b01), req_phy_addr,
                                req_reg_addr, 2'b10, req_wdata};
                w_div_nxt    = '0;
                w_half_nxt   = 1'b0;
                w_bit_nxt    = '0;
                w_ta_err_nxt = 1'b0;
            end
        end else begin
            w_div_nxt = w_tick ? '0 : r_div + 1'b1;

            if (w_rise) begin
                w_half_nxt = 1'b1;
                w_mdc_nxt  = 1'b1;
                // Second TA bit must be pulled low by the PHY.
                if ((r_state == S_TA) && (r_bit == C_TA_LAST)) begin
                    w_ta_err_nxt = mdio_i;
                end
                if (r_state == S_DATA) begin
                    w_rx_nxt = {r_rx[14:0], mdio_i};
                end
            end

            if (w_fall) begin
                w_half_nxt = 1'b0;
                w_mdc_nxt  = 1'b0;
                // Preamble bits come from a constant, not the shift register.
                if (r_state != S_PREAMBLE) begin
                    w_tx_nxt = {r_tx[30:0], 1'b0};
                end
                if (w_last) begin
                    w_bit_nxt = '0;
                    case (r_state)
                        S_PREAMBLE: w_state_nxt = S_HEADER;
                        S_HEADER:   w_state_nxt = S_TA;
                        S_TA:       w_state_nxt = S_DATA;
                        default: begin
                            w_state_nxt = S_DONE;
                            if (r_op) begin
                                w_rsp_rdata_nxt  = r_rx;
                                w_rsp_ta_err_nxt = r_ta_err;
                            end else begin
                                w_rsp_ta_err_nxt = 1'b0;
                            end
                        end
                    endcase
                end else begin
                    w_bit_nxt = r_bit + 1'b1;
                end
            end
        end

        // Pad drive for the bit that the next state/shift register describe.
        // This only changes at bit boundaries, i.e. when mdc falls or the
        // frame starts.
        case (w_state_nxt)
            S_PREAMBLE: begin
                w_mdio_o_nxt = 1'b1;
                w_mdio_t_nxt = 1'b0;
            end
            S_HEADER: begin
                w_mdio_o_nxt = w_tx_nxt[31];
                w_mdio_t_nxt = 1'b0;
            end
            S_TA, S_DATA: begin
                if (w_op_nxt) begin
                    w_mdio_o_nxt = 1'b1;
                    w_mdio_t_nxt = 1'b1;
                end else begin
                    w_mdio_o_nxt = w_tx_nxt[31];
                    w_mdio_t_nxt = 1'b0;
                end
            end
            default: begin
                w_mdio_o_nxt = 1'b1;
                w_mdio_t_nxt = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign req_ready  = w_idle_like;
    assign busy       = !w_idle_like;
    assign rsp_valid  = (r_state == S_DONE);
    assign rsp_rdata  = r_rsp_rdata;
    assign rsp_ta_err = r_rsp_ta_err;
    assign mdc        = r_mdc;
    assign mdio_o     = r_mdio_o;
    assign mdio_t     = r_mdio_t;

endmodule
`default_nettype wire

// File: tb/tb_mdio_frame_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdio_frame_engine
// Description : Self-checking bench for mdio_frame_engine. Instance A uses
//               C_CLK_DIV=2 / C_PREAMBLE_TIME=32, instance B uses
//               C_CLK_DIV=1 / C_PREAMBLE_TIME=0. Frames are captured on mdc
//               rising edges and compared with a frame built from the
//               Clause 22 field layout; a PHY model answers reads.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdio_frame_engine;

    localparam int A_DIV = 2;
    localparam int A_PRE = 32;
    localparam int B_DIV = 1;
    localparam int B_PRE = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // instance A
    logic        req_valid, req_ready, req_op;
    logic [4:0]  req_phy_addr, req_reg_addr;
    logic [15:0] req_wdata, rsp_rdata;
    logic        rsp_valid, rsp_ta_err, busy, mdc, mdio_i, mdio_o, mdio_t;

    // instance B
    logic        b_req_valid, b_req_ready, b_req_op;
    logic [4:0]  b_req_phy_addr, b_req_reg_addr;
    logic [15:0] b_req_wdata, b_rsp_rdata;
    logic        b_rsp_valid, b_rsp_ta_err, b_busy, b_mdc, b_mdio_i, b_mdio_o, b_mdio_t;

    mdio_frame_engine #(.C_CLK_DIV(A_DIV), .C_PREAMBLE_TIME(A_PRE)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_phy_addr(req_phy_addr), .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_ta_err(rsp_ta_err),
        .busy(busy), .mdc(mdc), .mdio_i(mdio_i), .mdio_o(mdio_o), .mdio_t(mdio_t)
    );

    mdio_frame_engine #(.C_CLK_DIV(B_DIV), .C_PREAMBLE_TIME(B_PRE)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_op(b_req_op),
        .req_phy_addr(b_req_phy_addr), .req_reg_addr(b_req_reg_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_ta_err(b_rsp_ta_err),
        .busy(b_busy), .mdc(b_mdc), .mdio_i(b_mdio_i), .mdio_o(b_mdio_o), .mdio_t(b_mdio_t)
    );

    int total = 0;
    int bad   = 0;
    int viol  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- reference frame model ----------------
    logic exp_o[$];
    logic exp_t[$];

    task automatic model_frame(input int pre, input logic op, input logic [4:0] phy,
                               input logic [4:0] ra, input logic [15:0] wd);
        logic [13:0] hdr;
        logic [17:0] tail;
        exp_o.delete();
        exp_t.delete();
        for (int i = 0; i < pre; i++) begin
            exp_o.push_back(1'b1); exp_t.push_back(1'b0);
        end
        hdr  = {2'b01, (op ? 2'b10 : 2'b01), phy, ra};
        tail = {2'b10, wd};
        for (int i = 13; i >= 0; i--) begin
            exp_o.push_back(hdr[i]); exp_t.push_back(1'b0);
        end
        for (int i = 17; i >= 0; i--) begin
            exp_o.push_back(op ? 1'b1 : tail[i]);
            exp_t.push_back(op);
        end
    endtask

    // ---------------- PHY model and capture for A ----------------
    logic        phy_present = 1'b0;
    logic [15:0] phy_data    = '0;
    logic        cap_o[$];
    logic        cap_t[$];
    logic        prev_mdc = 1'b0;

    // Value the PHY presents during frame bit k (counted from bit 0).
    function automatic logic phy_bit(input int k);
        if (!phy_present) return 1'b1;
        if (k == A_PRE + 15) return 1'b0;
        if (k >= A_PRE + 16 && k < A_PRE + 32) return phy_data[A_PRE + 31 - k];
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (mdc && !prev_mdc) begin
            cap_o.push_back(mdio_o);
            cap_t.push_back(mdio_t);
        end
        prev_mdc = mdc;
        if (rst_n) begin
            if (mdio_t && !mdio_o) viol++;
            if (mdc && !busy) viol++;
            if (busy == req_ready) viol++;
        end
        mdio_i = phy_bit(cap_o.size());
    end

    logic b_cap_o[$];
    logic b_cap_t[$];
    logic b_prev_mdc = 1'b0;
    always @(negedge clk) begin
        if (b_mdc && !b_prev_mdc) begin
            b_cap_o.push_back(b_mdio_o);
            b_cap_t.push_back(b_mdio_t);
        end
        b_prev_mdc = b_mdc;
    end

    task automatic check_frame_a(input string nm);
        int errs = 0;
        check({nm, "_len"}, cap_o.size(), exp_o.size());
        for (int i = 0; i < exp_o.size() && i < cap_o.size(); i++) begin
            if (cap_o[i] !== exp_o[i] || cap_t[i] !== exp_t[i]) errs++;
        end
        check({nm, "_biterrs"}, errs, 0);
    endtask

    // Wait for rsp_valid on A; returns number of negedges since accept edge.
    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 2000);
    endtask

    logic [15:0] last_rdata = '0;

    task automatic run_txn(input string nm, input logic op, input logic [4:0] phy,
                           input logic [4:0] ra, input logic [15:0] wd,
                           input logic present, input logic [15:0] pdata,
                           input logic [15:0] exp_rd, input logic exp_err);
        int lat;
        phy_present = present;
        phy_data    = pdata;
        @(negedge clk);
        check({nm, "_ready"}, req_ready, 1);
        req_valid = 1'b1; req_op = op; req_phy_addr = phy; req_reg_addr = ra; req_wdata = wd;
        @(posedge clk);
        cap_o.delete(); cap_t.delete();
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                // Changes after acceptance must not reach the frame.
                req_valid = 1'b0;
                req_op = ~op; req_phy_addr = ~phy; req_reg_addr = ~ra; req_wdata = ~wd;
            end
        end while (!rsp_valid && lat < 2000);
        model_frame(A_PRE, op, phy, ra, wd);
        check({nm, "_latency"}, lat, (A_PRE + 32) * 2 * A_DIV + 1);
        check_frame_a(nm);
        check({nm, "_rdata"}, rsp_rdata, exp_rd);
        check({nm, "_taerr"}, rsp_ta_err, exp_err);
        check({nm, "_done_pins"}, {busy, mdc, mdio_t, req_ready}, 4'b0011);
        @(negedge clk);
        check({nm, "_pulse"}, rsp_valid, 0);
        last_rdata = rsp_rdata;
    endtask

    typedef struct {
        logic        op;
        logic [4:0]  phy;
        logic [4:0]  ra;
        logic [15:0] wd;
        logic        present;
        logic [15:0] pdata;
        logic [15:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int lat;
        int seen;

        vecs[0] = '{1'b0, 5'h03, 5'h04, 16'h01E1, 1'b1, 16'h0000, 16'h0000, 1'b0};
        vecs[1] = '{1'b1, 5'h01, 5'h02, 16'h0000, 1'b1, 16'h796D, 16'h796D, 1'b0};
        vecs[2] = '{1'b1, 5'h01, 5'h02, 16'h0000, 1'b0, 16'h0000, 16'hFFFF, 1'b1};
        vecs[3] = '{1'b0, 5'h1F, 5'h1F, 16'hFFFF, 1'b0, 16'h0000, 16'hFFFF, 1'b0};
        vecs[4] = '{1'b1, 5'h00, 5'h1F, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b0};

        rst_n = 1'b0;
        req_valid = 1'b0; req_op = 1'b0; req_phy_addr = '0; req_reg_addr = '0; req_wdata = '0;
        b_req_valid = 1'b0; b_req_op = 1'b0; b_req_phy_addr = '0; b_req_reg_addr = '0;
        b_req_wdata = '0; b_mdio_i = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_pins", {mdc, mdio_o, mdio_t, req_ready, rsp_valid, rsp_ta_err, busy},
              7'b0111000);
        check("reset_rdata", rsp_rdata, 16'h0000);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // ---------------- directed table ----------------
        for (int i = 0; i < 5; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].phy, vecs[i].ra, vecs[i].wd,
                    vecs[i].present, vecs[i].pdata, vecs[i].exp_rd, vecs[i].exp_err);
        end

        // ---------------- randomized against the model ----------------
        for (int i = 0; i < 8; i++) begin
            logic        op, pr;
            logic [4:0]  phy, ra;
            logic [15:0] wd, pd, erd;
            op  = 1'($urandom_range(0, 1));
            pr  = 1'($urandom_range(0, 3) != 0);
            phy = 5'($urandom);
            ra  = 5'($urandom);
            wd  = 16'($urandom);
            pd  = 16'($urandom);
            erd = op ? (pr ? pd : 16'hFFFF) : last_rdata;
            run_txn($sformatf("rnd%0d", i), op, phy, ra, wd, pr, pd, erd, op && !pr);
        end

        // ---------------- back-to-back write then read ----------------
        phy_present = 1'b1;
        phy_data    = 16'hA5C3;
        @(negedge clk);
        req_valid = 1'b1; req_op = 1'b0; req_phy_addr = 5'h0A; req_reg_addr = 5'h11;
        req_wdata = 16'h1234;
        @(posedge clk);
        cap_o.delete(); cap_t.delete();
        @(negedge clk);
        req_op = 1'b1; req_phy_addr = 5'h15; req_reg_addr = 5'h06; req_wdata = 16'h0000;
        lat = 1;
        while (!rsp_valid && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        model_frame(A_PRE, 1'b0, 5'h0A, 5'h11, 16'h1234);
        check("b2b_wr_latency", lat, (A_PRE + 32) * 2 * A_DIV + 1);
        check_frame_a("b2b_wr");
        check("b2b_wr_resp", {rsp_ta_err, rsp_rdata}, {1'b0, last_rdata});
        check("b2b_gap_mdc", {mdc, req_ready}, 2'b01);
        @(posedge clk);
        cap_o.delete(); cap_t.delete();
        @(negedge clk);
        check("b2b_contiguous", busy, 1);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        model_frame(A_PRE, 1'b1, 5'h15, 5'h06, 16'h0000);
        check("b2b_rd_latency", lat, (A_PRE + 32) * 2 * A_DIV + 1);
        check_frame_a("b2b_rd");
        check("b2b_rd_resp", {rsp_ta_err, rsp_rdata}, {1'b0, 16'hA5C3});
        last_rdata = 16'hA5C3;
        @(negedge clk);

        // ---------------- reset in header bit 5 ----------------
        @(negedge clk);
        req_valid = 1'b1; req_op = 1'b0; req_phy_addr = 5'h07; req_reg_addr = 5'h09;
        req_wdata = 16'hC0DE;
        @(posedge clk);
        cap_o.delete(); cap_t.delete();
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        while (!(cap_o.size() == A_PRE + 5 && !mdc) && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        check("rst_reached_hdr5", busy, 1);
        rst_n = 1'b0;
        #1;
        check("rst_async_pins", {mdc, mdio_t, mdio_o, busy, rsp_valid, req_ready}, 6'b011001);
        check("rst_async_rdata", rsp_rdata, 16'h0000);
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("rst_no_rsp", seen, 0);
        last_rdata = 16'h0000;
        run_txn("post_rst", 1'b1, 5'h02, 5'h03, 16'h0000, 1'b1, 16'h5A17, 16'h5A17, 1'b0);

        // ---------------- instance B: no preamble, divide by 1 ----------------
        @(negedge clk);
        b_req_valid = 1'b1; b_req_op = 1'b0; b_req_phy_addr = 5'h12; b_req_reg_addr = 5'h0C;
        b_req_wdata = 16'hBEEF;
        @(posedge clk);
        b_cap_o.delete(); b_cap_t.delete();
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) b_req_valid = 1'b0;
        end while (!b_rsp_valid && lat < 500);
        check("nopre_latency", lat, (B_PRE + 32) * 2 * B_DIV + 1);
        model_frame(B_PRE, 1'b0, 5'h12, 5'h0C, 16'hBEEF);
        check("nopre_len", b_cap_o.size(), exp_o.size());
        begin
            int errs = 0;
            for (int i = 0; i < exp_o.size() && i < b_cap_o.size(); i++) begin
                if (b_cap_o[i] !== exp_o[i] || b_cap_t[i] !== exp_t[i]) errs++;
            end
            check("nopre_biterrs", errs, 0);
        end
        check("nopre_resp", {b_rsp_ta_err, b_rsp_rdata}, 17'h0_0000);

        check("invariant_violations", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL timeout: got no completion expected finish");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
